score_hand: RTL and testbench

- Baccarat hand scorer for the card engine datapath.
- Takes up to three 4-bit card codes, maps each to its Baccarat point value, and produces the hand total modulo 10.
- Result is registered with one-cycle latency and a valid flag, so the game FSM can sample it on a known cycle.
- Sits between the dealt-card registers and the win/draw comparison logic.

---
 rtl/score_hand.sv | 90 +++++++++
 tb/tb_score_hand.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/score_hand.sv
// score_hand: Baccarat hand scorer (sum of three card values mod 10), one-cycle registered result.
// Optional macro SCORE_HAND_NATURAL_EN adds the registered 'natural' output.
`default_nettype none

module score_hand #(
  parameter int CARD_W = 4
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              in_valid,
  input  logic [CARD_W-1:0] card1,
  input  logic [CARD_W-1:0] card2,
  input  logic [CARD_W-1:0] card3,
  output logic [CARD_W-1:0] total,
  output logic              out_valid,
`ifdef SCORE_HAND_NATURAL_EN
  output logic              natural,
`endif
  output logic              card_err
);

  localparam int SUM_W = CARD_W + 1;

  logic [CARD_W-1:0] val1, val2, val3;
  logic [SUM_W-1:0]  raw_sum;
  logic [CARD_W-1:0] sum_mod;
  logic              any_illegal;

  // Court cards and the illegal codes 14/15 all score zero.
  function automatic logic [CARD_W-1:0] card_value(input logic [CARD_W-1:0] code);
    if (code >= CARD_W'(1) && code <= CARD_W'(9)) begin
      return code;
    end
    return '0;
  endfunction

  function automatic logic is_illegal(input logic [CARD_W-1:0] code);
    return (code >= CARD_W'(14));
  endfunction

  always_comb begin
    val1        = card_value(card1);
    val2        = card_value(card2);
    val3        = card_value(card3);
    raw_sum     = SUM_W'(val1) + SUM_W'(val2) + SUM_W'(val3);
    any_illegal = is_illegal(card1) | is_illegal(card2) | is_illegal(card3);
  end

  // Raw sum never exceeds 27, so one subtraction of 20 or 10 is enough.
  always_comb begin
    sum_mod = raw_sum[CARD_W-1:0];
    if (raw_sum >= SUM_W'(20)) begin
      sum_mod = CARD_W'(raw_sum - SUM_W'(20));
    end else if (raw_sum >= SUM_W'(10)) begin
      sum_mod = CARD_W'(raw_sum - SUM_W'(10));
    end
  end

`ifdef SCORE_HAND_NATURAL_EN
  logic natural_next;

  always_comb begin
    natural_next = (card3 == '0) && (card1 != '0) && (card2 != '0) &&
                   (sum_mod >= CARD_W'(8));
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetb) begin
      total     <= '0;
      out_valid <= 1'b0;
      card_err  <= 1'b0;
`ifdef SCORE_HAND_NATURAL_EN
      natural   <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        total    <= sum_mod;
        card_err <= any_illegal;
`ifdef SCORE_HAND_NATURAL_EN
        natural  <= natural_next;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_score_hand.sv
// tb_score_hand: directed vectors into a scoreboard queue; a monitor pops and compares on out_valid.
`default_nettype none

module tb_score_hand;

  logic       clk = 1'b0;
  logic       resetb;
  logic       in_valid;
  logic [3:0] card1, card2, card3;
  logic [3:0] total;
  logic       out_valid;
  logic       card_err;
`ifdef SCORE_HAND_NATURAL_EN
  logic       natural;
`endif

  score_hand dut (
    .clk       (clk),
    .resetb    (resetb),
    .in_valid  (in_valid),
    .card1     (card1),
    .card2     (card2),
    .card3     (card3),
    .total     (total),
    .out_valid (out_valid),
`ifdef SCORE_HAND_NATURAL_EN
    .natural   (natural),
`endif
    .card_err  (card_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] t;
    logic       e;
    logic       n;
    int         cyc;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cycle   = 0;
  int   applied = 0;
  int   errors  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input int act, input int req);
    applied++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Issue one request on the falling edge and record its hand-computed result.
  task automatic issue(input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3,
                       input logic [3:0] et, input logic ee, input logic en, input string name);
    exp_t x;
    @(negedge clk);
    resetb   = 1'b1;
    in_valid = 1'b1;
    card1    = c1;
    card2    = c2;
    card3    = c3;
    x.t = et; x.e = ee; x.n = en; x.cyc = cycle; x.name = name;
    q.push_back(x);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    card1 = 4'd0; card2 = 4'd0; card3 = 4'd0;
  endtask

  // Monitor: every out_valid must match the oldest outstanding request, exactly one cycle later.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          x = q.pop_front();
          check({x.name, "_total"}, int'(total), int'(x.t));
          check({x.name, "_err"}, int'(card_err), int'(x.e));
          check({x.name, "_latency"}, cycle - x.cyc, 1);
`ifdef SCORE_HAND_NATURAL_EN
          check({x.name, "_natural"}, int'(natural), int'(x.n));
`endif
        end
      end
    end
  end

  initial begin
    resetb = 1'b0; in_valid = 1'b1;
    card1 = 4'd9; card2 = 4'd9; card3 = 4'd9;
    // Reset has priority over a pending request.
    repeat (2) @(negedge clk);
    check("reset_total", int'(total), 0);
    check("reset_valid", int'(out_valid), 0);
    check("reset_err", int'(card_err), 0);

    issue(4'd1,  4'd2,  4'd3,  4'd6, 1'b0, 1'b0, "low_123");
    issue(4'd1,  4'd2,  4'd11, 4'd3, 1'b0, 1'b0, "court_12J");
    issue(4'd1,  4'd10, 4'd11, 4'd1, 1'b0, 1'b0, "court_1TJ");
    issue(4'd12, 4'd10, 4'd11, 4'd0, 1'b0, 1'b0, "court_QTJ");
    issue(4'd11, 4'd2,  4'd1,  4'd3, 1'b0, 1'b0, "perm_J21");
    issue(4'd3,  4'd1,  4'd2,  4'd6, 1'b0, 1'b0, "perm_312");
    issue(4'd8,  4'd8,  4'd8,  4'd4, 1'b0, 1'b0, "wrap_888");
    idle();
    @(negedge clk);
    check("hold_valid", int'(out_valid), 0);
    check("hold_total", int'(total), 4);

    issue(4'd9,  4'd9,  4'd9,  4'd7, 1'b0, 1'b0, "wrap_999");
    issue(4'd5,  4'd5,  4'd0,  4'd0, 1'b0, 1'b0, "wrap_550");
    issue(4'd7,  4'd7,  4'd7,  4'd1, 1'b0, 1'b0, "wrap_777");
    issue(4'd14, 4'd3,  4'd0,  4'd3, 1'b1, 1'b0, "illegal_14");
    issue(4'd3,  4'd0,  4'd0,  4'd3, 1'b0, 1'b0, "legal_300");
    issue(4'd15, 4'd15, 4'd15, 4'd0, 1'b1, 1'b0, "illegal_15s");
    issue(4'd4,  4'd5,  4'd0,  4'd9, 1'b0, 1'b1, "nat_450");
    issue(4'd4,  4'd4,  4'd1,  4'd9, 1'b0, 1'b0, "nat_441");
    issue(4'd13, 4'd8,  4'd0,  4'd8, 1'b0, 1'b1, "nat_K80");
    issue(4'd3,  4'd3,  4'd0,  4'd6, 1'b0, 1'b0, "nat_330");
    issue(4'd0,  4'd9,  4'd9,  4'd8, 1'b0, 1'b0, "nat_099");
    issue(4'd9,  4'd0,  4'd0,  4'd9, 1'b0, 1'b0, "nat_900");
    issue(4'd9,  4'd9,  4'd0,  4'd8, 1'b0, 1'b1, "nat_990");

    // A request presented together with reset is discarded.
    @(negedge clk);
    resetb = 1'b0; in_valid = 1'b1;
    card1 = 4'd14; card2 = 4'd4; card3 = 4'd0;
    @(negedge clk);
    resetb = 1'b1; in_valid = 1'b0;
    check("midreset_valid", int'(out_valid), 0);
    check("midreset_total", int'(total), 0);
    check("midreset_err", int'(card_err), 0);

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule

`default_nettype wire
